snitch_icache_l0_refill_arbiter: RTL and testbench

//  Shares one L1 refill request/response channel between NR_PORTS private L0 caches.
//  - Requests: demand refills have priority over prefetches; round-robin within each class.
//  - Responses: routed back to the owning L0 by the port field of the response ID.
//  - Caps refills in flight per L0.
//  - Position: sits between the L0 out_req/out_rsp ports and the shared L1 lookup.

---
 rtl/snitch_icache_l0_refill_arbiter_if.sv | 61 ++++++
 rtl/snitch_icache_l0_refill_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_snitch_icache_l0_refill_arbiter.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/snitch_icache_l0_refill_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : snitch_icache_l0_refill_arbiter_if
// Purpose  : Bundles the L0-side refill ports (NR_PORTS flattened lanes) and
//            the shared L1-side refill channel into one interface.
// Ports    : in_req_*  : per-L0 refill requests (addr, id, valid/ready)
//            in_rsp_*  : per-L0 refill responses (data, error, id, valid/ready)
//            out_req_* : arbitrated request towards L1
//            out_rsp_* : L1 response to be routed back
// Modports : slave  - the arbiter's view (directions as named by _i/_o)
//            master - the surrounding logic driving/observing the arbiter
// Revision : 1.0 - initial release
// ============================================================================
interface snitch_icache_l0_refill_arbiter_if #(
   parameter int NR_PORTS   = 4,
   parameter int FETCH_AW   = 32,
   parameter int LINE_WIDTH = 128,
   parameter int ID_WIDTH   = 3
);
   logic [NR_PORTS*FETCH_AW-1:0]   in_req_addr_i;
   logic [NR_PORTS*ID_WIDTH-1:0]   in_req_id_i;
   logic [NR_PORTS-1:0]            in_req_valid_i;
   logic [NR_PORTS-1:0]            in_req_ready_o;
   logic [NR_PORTS*LINE_WIDTH-1:0] in_rsp_data_o;
   logic [NR_PORTS-1:0]            in_rsp_error_o;
   logic [NR_PORTS*ID_WIDTH-1:0]   in_rsp_id_o;
   logic [NR_PORTS-1:0]            in_rsp_valid_o;
   logic [NR_PORTS-1:0]            in_rsp_ready_i;
   logic [FETCH_AW-1:0]            out_req_addr_o;
   logic [ID_WIDTH-1:0]            out_req_id_o;
   logic                           out_req_valid_o;
   logic                           out_req_ready_i;
   logic [LINE_WIDTH-1:0]          out_rsp_data_i;
   logic                           out_rsp_error_i;
   logic [ID_WIDTH-1:0]            out_rsp_id_i;
   logic                           out_rsp_valid_i;
   logic                           out_rsp_ready_o;

   modport slave (
      input  in_req_addr_i, in_req_id_i, in_req_valid_i,
      output in_req_ready_o,
      output in_rsp_data_o, in_rsp_error_o, in_rsp_id_o, in_rsp_valid_o,
      input  in_rsp_ready_i,
      output out_req_addr_o, out_req_id_o, out_req_valid_o,
      input  out_req_ready_i,
      input  out_rsp_data_i, out_rsp_error_i, out_rsp_id_i, out_rsp_valid_i,
      output out_rsp_ready_o
   );

   modport master (
      output in_req_addr_i, in_req_id_i, in_req_valid_i,
      input  in_req_ready_o,
      input  in_rsp_data_o, in_rsp_error_o, in_rsp_id_o, in_rsp_valid_o,
      output in_rsp_ready_i,
      input  out_req_addr_o, out_req_id_o, out_req_valid_o,
      output out_req_ready_i,
      output out_rsp_data_i, out_rsp_error_i, out_rsp_id_i, out_rsp_valid_i,
      input  out_rsp_ready_o
   );
endinterface
`default_nettype wire

// File: rtl/snitch_icache_l0_refill_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : snitch_icache_l0_refill_arbiter
// Purpose  : Shares one L1 refill channel between NR_PORTS private L0 caches.
//            Demand refills beat prefetches, round-robin within a class, a
//            stalled grant is held until its handshake, responses are routed
//            by the port field of their ID, and each L0 is capped at
//            MAX_OUTSTANDING refills in flight.
// Ports    : clk_i  - clock
//            rst_ni - asynchronous reset, active low
//            bus    - refill interface (slave modport), see the _if file
// Revision : 1.0 - initial release
// ============================================================================
module snitch_icache_l0_refill_arbiter #(
   parameter int NR_PORTS        = 4,
   parameter int FETCH_AW        = 32,
   parameter int LINE_WIDTH      = 128,
   parameter int ID_WIDTH        = 3,
   parameter int MAX_OUTSTANDING = 2,
   parameter bit ASSERT_EN       = 1'b1
) (
   input  logic clk_i,
   input  logic rst_ni,
   snitch_icache_l0_refill_arbiter_if.slave bus
);
   localparam int PW = $clog2(NR_PORTS);
   localparam int CW = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CW-1:0] C_MAX = CW'(MAX_OUTSTANDING);

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_LOCKED = 1'b1;

   logic [0:0]          state_q, state_d;
   logic [PW-1:0]       lock_idx_q, lock_idx_d;
   logic [PW-1:0]       rr_q, rr_d;
   logic [CW-1:0]       cnt_q [NR_PORTS];
   logic [CW-1:0]       cnt_d [NR_PORTS];

   logic [FETCH_AW-1:0] addr_arr [NR_PORTS];
   logic [ID_WIDTH-1:0] id_arr   [NR_PORTS];
   logic [NR_PORTS-1:0] eligible, demand, prefetch, cand;
   logic [PW-1:0]       rr_pick;
   logic                rr_found;
   logic [PW:0]         rr_sum;
   logic [PW-1:0]       grant_idx;
   logic                req_valid;
   logic                req_hs;

   logic [ID_WIDTH-2:0] rsp_port;
   logic                rsp_port_ok;
   logic                rsp_ready;
   logic                rsp_hs;
   logic                rsp_cnt_zero;
   logic                rsp_underflow;

   // ---------------------------------------------------------------- request
   for (genvar i = 0; i < NR_PORTS; i++) begin : g_port
      assign addr_arr[i] = bus.in_req_addr_i[i*FETCH_AW +: FETCH_AW];
      assign id_arr[i]   = bus.in_req_id_i[i*ID_WIDTH +: ID_WIDTH];
      assign eligible[i] = bus.in_req_valid_i[i] && (cnt_q[i] < C_MAX);
      assign demand[i]   = eligible[i] && !id_arr[i][0];
      assign prefetch[i] = eligible[i] &&  id_arr[i][0];
      assign bus.in_req_ready_o[i] = req_valid && bus.out_req_ready_i
                                     && (grant_idx == PW'(i));
      // Line, error and ID are broadcast; only the valid is steered.
      assign bus.in_rsp_data_o[i*LINE_WIDTH +: LINE_WIDTH] = bus.out_rsp_data_i;
      assign bus.in_rsp_id_o[i*ID_WIDTH +: ID_WIDTH]       = bus.out_rsp_id_i;
      assign bus.in_rsp_error_o[i] = bus.out_rsp_error_i;
      assign bus.in_rsp_valid_o[i] = bus.out_rsp_valid_i
                                     && (rsp_port == (ID_WIDTH-1)'(i));
   end

   // Prefetches only compete when no eligible demand exists.
   assign cand = (|demand) ? demand : prefetch;

   // First candidate at or after rr_q, wrapping modulo NR_PORTS.
   always_comb begin
      rr_pick  = rr_q;
      rr_found = 1'b0;
      rr_sum   = '0;
      for (int k = 0; k < NR_PORTS; k++) begin
         rr_sum = {1'b0, rr_q} + (PW+1)'(k);
         if (rr_sum >= (PW+1)'(NR_PORTS)) begin
            rr_sum = rr_sum - (PW+1)'(NR_PORTS);
         end
         if (!rr_found && cand[rr_sum[PW-1:0]]) begin
            rr_found = 1'b1;
            rr_pick  = rr_sum[PW-1:0];
         end
      end
   end

   // ------------------------------------------------------------- lock FSM
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ST_IDLE;
         lock_idx_q <= '0;
      end else begin
         state_q    <= state_d;
         lock_idx_q <= lock_idx_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      lock_idx_d = lock_idx_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid && !bus.out_req_ready_i) begin
               state_d    = ST_LOCKED;
               lock_idx_d = grant_idx;
            end
         end
         ST_LOCKED: begin
            if (req_valid && bus.out_req_ready_i) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // A stalled request keeps its grant so addr/id stay stable towards L1,
   // even if a higher-priority demand shows up in the meantime.
   always_comb begin
      grant_idx = rr_pick;
      req_valid = |cand;
      if (state_q == ST_LOCKED) begin
         grant_idx = lock_idx_q;
         req_valid = bus.in_req_valid_i[lock_idx_q];
      end
   end

   assign req_hs              = req_valid && bus.out_req_ready_i;
   assign bus.out_req_valid_o = req_valid;
   assign bus.out_req_addr_o  = addr_arr[grant_idx];
   assign bus.out_req_id_o    = id_arr[grant_idx];

   // --------------------------------------------------------------- response
   assign rsp_port    = bus.out_rsp_id_i[ID_WIDTH-1:1];
   assign rsp_port_ok = {1'b0, rsp_port} < ID_WIDTH'(NR_PORTS);

   // Out-of-range port IDs keep ready high so the bogus response drains.
   always_comb begin
      rsp_ready    = 1'b1;
      rsp_cnt_zero = 1'b0;
      for (int i = 0; i < NR_PORTS; i++) begin
         if (rsp_port == (ID_WIDTH-1)'(i)) begin
            rsp_ready    = bus.in_rsp_ready_i[i];
            rsp_cnt_zero = (cnt_q[i] == '0);
         end
      end
   end

   assign bus.out_rsp_ready_o = rsp_ready;
   assign rsp_hs        = bus.out_rsp_valid_i && rsp_ready && rsp_port_ok;
   assign rsp_underflow = rsp_hs && rsp_cnt_zero;

   // -------------------------------------------------------------- counters
   always_comb begin
      for (int i = 0; i < NR_PORTS; i++) begin
         cnt_d[i] = cnt_q[i];
         case ({req_hs && (grant_idx == PW'(i)),
                rsp_hs && (rsp_port == (ID_WIDTH-1)'(i)) && (cnt_q[i] != '0)})
            2'b10:   cnt_d[i] = cnt_q[i] + CW'(1);
            2'b01:   cnt_d[i] = cnt_q[i] - CW'(1);
            default: cnt_d[i] = cnt_q[i];
         endcase
      end
   end

   always_comb begin
      rr_d = rr_q;
      if (req_hs) begin
         rr_d = (grant_idx == PW'(NR_PORTS - 1)) ? '0 : grant_idx + PW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_q <= '0;
         for (int i = 0; i < NR_PORTS; i++) cnt_q[i] <= '0;
      end else begin
         rr_q <= rr_d;
         for (int i = 0; i < NR_PORTS; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   // ------------------------------------------------------------- assertions
   if (ASSERT_EN) begin : g_assert
      always_ff @(posedge clk_i) begin
         if (rst_ni) begin
            assert (!(state_q == ST_LOCKED && !bus.in_req_valid_i[lock_idx_q]))
               else $error("locked port dropped its request valid");
            assert (!(bus.out_rsp_valid_i && !rsp_port_ok))
               else $error("response ID addresses a non-existent port");
            assert (!rsp_underflow)
               else $error("response for a port with no refill in flight");
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_snitch_icache_l0_refill_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_snitch_icache_l0_refill_arbiter
// Purpose  : Self-checking bench for the L0 refill arbiter: directed scenarios
//            plus randomized traffic against a behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_snitch_icache_l0_refill_arbiter;
   localparam int N    = 4;
   localparam int AW   = 32;
   localparam int LW   = 128;
   localparam int IW   = 3;
   localparam int MAXO = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   snitch_icache_l0_refill_arbiter_if #(
      .NR_PORTS(N), .FETCH_AW(AW), .LINE_WIDTH(LW), .ID_WIDTH(IW)
   ) ifc ();

   // Stray-response scenarios are exercised on purpose, so the in-design
   // checks are disabled here and the underflow flag is observed directly.
   snitch_icache_l0_refill_arbiter #(
      .NR_PORTS(N), .FETCH_AW(AW), .LINE_WIDTH(LW), .ID_WIDTH(IW),
      .MAX_OUTSTANDING(MAXO), .ASSERT_EN(1'b0)
   ) dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (ifc.slave)
   );

   int errors = 0;
   int checks = 0;

   // Reference model state
   int m_cnt [N];
   int m_rr;
   bit m_lock;
   int m_lidx;

   // Model predictions for the current cycle
   int             e_win;
   bit             e_valid;
   logic [N-1:0]   e_req_ready;
   logic [N-1:0]   e_rsp_valid;
   bit             e_rsp_ready;
   bit             e_underflow;

   function automatic bit elig(int j);
      return ifc.in_req_valid_i[j] && (m_cnt[j] < MAXO);
   endfunction

   function automatic void model_eval();
      bit any_dem;
      int p;
      any_dem = 0;
      for (int j = 0; j < N; j++)
         if (elig(j) && !ifc.in_req_id_i[j*IW]) any_dem = 1;
      e_win   = 0;
      e_valid = 0;
      if (m_lock) begin
         e_win   = m_lidx;
         e_valid = ifc.in_req_valid_i[m_lidx];
      end else begin
         for (int k = 0; k < N; k++) begin
            int j;
            j = (m_rr + k) % N;
            if (!e_valid && elig(j) && (ifc.in_req_id_i[j*IW] == !any_dem)) begin
               e_valid = 1;
               e_win   = j;
            end
         end
      end
      e_req_ready = (e_valid && ifc.out_req_ready_i) ? N'(1 << e_win) : '0;
      p = int'(ifc.out_rsp_id_i[IW-1:1]);
      e_rsp_valid = (ifc.out_rsp_valid_i && p < N) ? N'(1 << p) : '0;
      e_rsp_ready = (p < N) ? ifc.in_rsp_ready_i[p] : 1'b1;
      e_underflow = ifc.out_rsp_valid_i && e_rsp_ready && (p < N) && (m_cnt[p] == 0);
   endfunction

   function automatic void model_reset();
      for (int j = 0; j < N; j++) m_cnt[j] = 0;
      m_rr = 0; m_lock = 0; m_lidx = 0;
   endfunction

   // Clock one cycle and advance the model with this cycle's handshakes.
   task automatic advance();
      bit hs, dec;
      int p;
      hs  = e_valid && ifc.out_req_ready_i;
      p   = int'(ifc.out_rsp_id_i[IW-1:1]);
      dec = ifc.out_rsp_valid_i && e_rsp_ready && (p < N) && (m_cnt[p] > 0);
      @(posedge clk);
      if (dec) m_cnt[p] = m_cnt[p] - 1;
      if (hs) begin
         m_cnt[e_win] = m_cnt[e_win] + 1;
         m_rr   = (e_win + 1) % N;
         m_lock = 0;
      end else if (e_valid && !m_lock) begin
         m_lock = 1;
         m_lidx = e_win;
      end
      #1;
   endtask

   task automatic set_req(int port, bit valid, bit pf, logic [AW-1:0] addr);
      ifc.in_req_valid_i[port]         = valid;
      ifc.in_req_id_i[port*IW +: IW]   = {2'(port), pf};
      ifc.in_req_addr_i[port*AW +: AW] = addr;
   endtask

   task automatic clear_inputs();
      ifc.in_req_addr_i   = '0;
      ifc.in_req_id_i     = '0;
      ifc.in_req_valid_i  = '0;
      ifc.in_rsp_ready_i  = '0;
      ifc.out_req_ready_i = 1'b0;
      ifc.out_rsp_data_i  = '0;
      ifc.out_rsp_error_i = 1'b0;
      ifc.out_rsp_id_i    = '0;
      ifc.out_rsp_valid_i = 1'b0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [AW-1:0] addr_of(int port);
      return 32'h1000_0000 + AW'(port * 16);
   endfunction

   // ------------------------------------------------------------- scenarios
   task automatic test_reset();
      do_reset();
      @(negedge clk);
      checks++; if (ifc.out_req_valid_o !== 1'b0) begin errors++;
         $display("FAIL reset_out_req_valid got %b want 0", ifc.out_req_valid_o); end
      checks++; if (ifc.in_req_ready_o !== 4'b0) begin errors++;
         $display("FAIL reset_in_req_ready got %b want 0000", ifc.in_req_ready_o); end
      checks++; if (ifc.in_rsp_valid_o !== 4'b0) begin errors++;
         $display("FAIL reset_in_rsp_valid got %b want 0000", ifc.in_rsp_valid_o); end
      checks++; if (ifc.out_rsp_ready_o !== 1'b0) begin errors++;
         $display("FAIL reset_out_rsp_ready got %b want 0", ifc.out_rsp_ready_o); end
      checks++; if (dut.rr_q !== 2'd0) begin errors++;
         $display("FAIL reset_rr got %0d want 0", dut.rr_q); end
      for (int i = 0; i < N; i++) begin
         checks++; if (dut.cnt_q[i] !== 2'd0) begin errors++;
            $display("FAIL reset_cnt%0d got %0d want 0", i, dut.cnt_q[i]); end
      end
      advance();
   endtask

   task automatic test_rr_order();
      do_reset();
      for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, addr_of(i));
      ifc.out_req_ready_i = 1'b1;
      for (int k = 0; k < N; k++) begin
         @(negedge clk); model_eval();
         checks++; if (ifc.out_req_id_o !== {2'(k), 1'b0}) begin errors++;
            $display("FAIL rr_id step%0d got %b want %b", k, ifc.out_req_id_o, {2'(k), 1'b0}); end
         checks++; if (ifc.out_req_addr_o !== addr_of(k)) begin errors++;
            $display("FAIL rr_addr step%0d got %h want %h", k, ifc.out_req_addr_o, addr_of(k)); end
         checks++; if (ifc.in_req_ready_o !== N'(1 << k)) begin errors++;
            $display("FAIL rr_ready step%0d got %b want %b", k, ifc.in_req_ready_o, N'(1 << k)); end
         advance();
      end
      ifc.in_req_valid_i = '0;
      checks++; if (dut.rr_q !== 2'd0) begin errors++;
         $display("FAIL rr_wrap got %0d want 0", dut.rr_q); end
      for (int i = 0; i < N; i++) begin
         checks++; if (dut.cnt_q[i] !== 2'd1) begin errors++;
            $display("FAIL rr_cnt%0d got %0d want 1", i, dut.cnt_q[i]); end
      end
   endtask

   task automatic test_priority();
      do_reset();
      set_req(1, 1'b1, 1'b1, addr_of(1));
      set_req(2, 1'b1, 1'b0, addr_of(2));
      ifc.out_req_ready_i = 1'b1;
      @(negedge clk); model_eval();
      checks++; if (ifc.in_req_ready_o !== 4'b0100) begin errors++;
         $display("FAIL prio_demand_first got %b want 0100", ifc.in_req_ready_o); end
      checks++; if (ifc.out_req_id_o !== 3'b100) begin errors++;
         $display("FAIL prio_demand_id got %b want 100", ifc.out_req_id_o); end
      advance();
      set_req(2, 1'b0, 1'b0, addr_of(2));
      @(negedge clk); model_eval();
      checks++; if (ifc.in_req_ready_o !== 4'b0010) begin errors++;
         $display("FAIL prio_prefetch_next got %b want 0010", ifc.in_req_ready_o); end
      checks++; if (ifc.out_req_id_o !== 3'b011) begin errors++;
         $display("FAIL prio_prefetch_id got %b want 011", ifc.out_req_id_o); end
      advance();
      clear_inputs();
   endtask

   task automatic test_lock();
      do_reset();
      set_req(3, 1'b1, 1'b0, 32'hCAFE_0030);
      ifc.out_req_ready_i = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk); model_eval();
         checks++; if (ifc.out_req_valid_o !== 1'b1 || ifc.out_req_id_o !== 3'b110
                       || ifc.out_req_addr_o !== 32'hCAFE_0030) begin errors++;
            $display("FAIL lock_hold cyc%0d got v=%b id=%b addr=%h want v=1 id=110 addr=cafe0030",
                     c, ifc.out_req_valid_o, ifc.out_req_id_o, ifc.out_req_addr_o); end
         checks++; if (ifc.in_req_ready_o !== 4'b0) begin errors++;
            $display("FAIL lock_ready cyc%0d got %b want 0000", c, ifc.in_req_ready_o); end
         advance();
         set_req(0, 1'b1, 1'b0, addr_of(0));
      end
      ifc.out_req_ready_i = 1'b1;
      @(negedge clk); model_eval();
      checks++; if (ifc.in_req_ready_o !== 4'b1000 || ifc.out_req_id_o !== 3'b110) begin errors++;
         $display("FAIL lock_release got ready=%b id=%b want ready=1000 id=110",
                  ifc.in_req_ready_o, ifc.out_req_id_o); end
      advance();
      set_req(3, 1'b0, 1'b0, 32'hCAFE_0030);
      @(negedge clk); model_eval();
      checks++; if (ifc.in_req_ready_o !== 4'b0001 || ifc.out_req_id_o !== 3'b000) begin errors++;
         $display("FAIL lock_waiter got ready=%b id=%b want ready=0001 id=000",
                  ifc.in_req_ready_o, ifc.out_req_id_o); end
      advance();
      clear_inputs();
   endtask

   task automatic test_outstanding();
      do_reset();
      set_req(0, 1'b1, 1'b0, addr_of(0));
      ifc.out_req_ready_i = 1'b1;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk); model_eval();
         checks++; if (ifc.in_req_ready_o !== 4'b0001) begin errors++;
            $display("FAIL outst_grant%0d got %b want 0001", c, ifc.in_req_ready_o); end
         advance();
      end
      @(negedge clk); model_eval();
      checks++; if (ifc.out_req_valid_o !== 1'b0) begin errors++;
         $display("FAIL outst_capped got %b want 0", ifc.out_req_valid_o); end
      advance();
      ifc.out_rsp_id_i    = 3'b000;
      ifc.out_rsp_valid_i = 1'b1;
      ifc.in_rsp_ready_i  = 4'b0001;
      @(negedge clk); model_eval();
      checks++; if (ifc.out_req_valid_o !== 1'b0 || ifc.out_rsp_ready_o !== 1'b1
                    || ifc.in_rsp_valid_o !== 4'b0001) begin errors++;
         $display("FAIL outst_rsp_cycle got rv=%b rr=%b iv=%b want rv=0 rr=1 iv=0001",
                  ifc.out_req_valid_o, ifc.out_rsp_ready_o, ifc.in_rsp_valid_o); end
      advance();
      ifc.out_rsp_valid_i = 1'b0;
      @(negedge clk); model_eval();
      checks++; if (ifc.out_req_valid_o !== 1'b1 || ifc.in_req_ready_o !== 4'b0001) begin errors++;
         $display("FAIL outst_third got v=%b ready=%b want v=1 ready=0001",
                  ifc.out_req_valid_o, ifc.in_req_ready_o); end
      advance();
      clear_inputs();
   endtask

   task automatic test_rsp_route();
      logic [LW-1:0] line;
      do_reset();
      set_req(2, 1'b1, 1'b1, addr_of(2));
      ifc.out_req_ready_i = 1'b1;
      @(negedge clk); model_eval();
      checks++; if (ifc.in_req_ready_o !== 4'b0100) begin errors++;
         $display("FAIL route_setup got %b want 0100", ifc.in_req_ready_o); end
      advance();
      clear_inputs();
      line = {$urandom, $urandom, $urandom, $urandom};
      ifc.out_rsp_data_i  = line;
      ifc.out_rsp_id_i    = 3'b101;
      ifc.out_rsp_valid_i = 1'b1;
      ifc.in_rsp_ready_i  = 4'b1011;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk); model_eval();
         checks++; if (ifc.in_rsp_valid_o !== 4'b0100 || ifc.out_rsp_ready_o !== 1'b0) begin errors++;
            $display("FAIL route_stall cyc%0d got iv=%b rr=%b want iv=0100 rr=0",
                     c, ifc.in_rsp_valid_o, ifc.out_rsp_ready_o); end
         checks++; if (ifc.in_rsp_data_o[2*LW +: LW] !== line
                       || ifc.in_rsp_id_o[2*IW +: IW] !== 3'b101) begin errors++;
            $display("FAIL route_payload cyc%0d got id=%b want id=101 (data %s)", c,
                     ifc.in_rsp_id_o[2*IW +: IW],
                     (ifc.in_rsp_data_o[2*LW +: LW] === line) ? "ok" : "wrong"); end
         checks++; if (dut.cnt_q[2] !== 2'd1) begin errors++;
            $display("FAIL route_cnt_held cyc%0d got %0d want 1", c, dut.cnt_q[2]); end
         advance();
      end
      ifc.in_rsp_ready_i = 4'b1111;
      @(negedge clk); model_eval();
      checks++; if (ifc.out_rsp_ready_o !== 1'b1) begin errors++;
         $display("FAIL route_ready got %b want 1", ifc.out_rsp_ready_o); end
      advance();
      ifc.out_rsp_valid_i = 1'b0;
      checks++; if (dut.cnt_q[2] !== 2'd0) begin errors++;
         $display("FAIL route_cnt_dec got %0d want 0", dut.cnt_q[2]); end
   endtask

   task automatic test_reset_midop();
      do_reset();
      set_req(0, 1'b1, 1'b0, addr_of(0));
      set_req(1, 1'b1, 1'b0, addr_of(1));
      ifc.out_req_ready_i = 1'b1;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk); model_eval(); advance();
         set_req(c, 1'b0, 1'b0, addr_of(c));
      end
      clear_inputs();
      @(negedge clk);
      checks++; if (dut.cnt_q[0] !== 2'd1 || dut.cnt_q[1] !== 2'd1) begin errors++;
         $display("FAIL midrst_inflight got %0d/%0d want 1/1", dut.cnt_q[0], dut.cnt_q[1]); end
      rst_n = 1'b0;
      #1;
      model_reset();
      checks++; if (dut.cnt_q[0] !== 2'd0 || dut.cnt_q[1] !== 2'd0 || dut.rr_q !== 2'd0
                    || dut.state_q !== 1'b0) begin errors++;
         $display("FAIL midrst_clear got cnt=%0d/%0d rr=%0d lock=%b want 0/0 0 0",
                  dut.cnt_q[0], dut.cnt_q[1], dut.rr_q, dut.state_q); end
      checks++; if (ifc.out_req_valid_o !== 1'b0 || ifc.in_req_ready_o !== 4'b0
                    || ifc.in_rsp_valid_o !== 4'b0) begin errors++;
         $display("FAIL midrst_outputs got rv=%b rdy=%b iv=%b want 0",
                  ifc.out_req_valid_o, ifc.in_req_ready_o, ifc.in_rsp_valid_o); end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      ifc.out_rsp_id_i    = 3'b010;
      ifc.out_rsp_valid_i = 1'b1;
      ifc.in_rsp_ready_i  = 4'b1111;
      @(negedge clk); model_eval();
      checks++; if (ifc.out_rsp_ready_o !== 1'b1 || ifc.in_rsp_valid_o !== 4'b0010) begin errors++;
         $display("FAIL stray_route got rr=%b iv=%b want rr=1 iv=0010",
                  ifc.out_rsp_ready_o, ifc.in_rsp_valid_o); end
      checks++; if (dut.rsp_underflow !== e_underflow || e_underflow !== 1'b1) begin errors++;
         $display("FAIL stray_underflow got %b want 1", dut.rsp_underflow); end
      advance();
      ifc.out_rsp_valid_i = 1'b0;
      checks++; if (dut.cnt_q[1] !== 2'd0) begin errors++;
         $display("FAIL stray_cnt got %0d want 0", dut.cnt_q[1]); end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!(m_lock && m_lidx == i))
               set_req(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom));
         end
         ifc.out_req_ready_i = ($urandom_range(0, 3) != 0);
         ifc.out_rsp_valid_i = 1'($urandom_range(0, 1));
         ifc.out_rsp_id_i    = IW'($urandom);
         ifc.out_rsp_data_i  = {$urandom, $urandom, $urandom, $urandom};
         ifc.out_rsp_error_i = 1'($urandom);
         ifc.in_rsp_ready_i  = N'($urandom);
         @(negedge clk); model_eval();
         checks++; if (ifc.out_req_valid_o !== e_valid) begin errors++;
            $display("FAIL rnd_req_valid cyc%0d got %b want %b", c, ifc.out_req_valid_o, e_valid); end
         if (e_valid) begin
            checks++; if (ifc.out_req_id_o !== ifc.in_req_id_i[e_win*IW +: IW]
                          || ifc.out_req_addr_o !== ifc.in_req_addr_i[e_win*AW +: AW]) begin errors++;
               $display("FAIL rnd_grant cyc%0d got id=%b want port %0d id=%b", c,
                        ifc.out_req_id_o, e_win, ifc.in_req_id_i[e_win*IW +: IW]); end
         end
         checks++; if (ifc.in_req_ready_o !== e_req_ready) begin errors++;
            $display("FAIL rnd_req_ready cyc%0d got %b want %b", c, ifc.in_req_ready_o, e_req_ready); end
         checks++; if (ifc.in_rsp_valid_o !== e_rsp_valid || ifc.out_rsp_ready_o !== e_rsp_ready) begin errors++;
            $display("FAIL rnd_rsp cyc%0d got iv=%b rr=%b want iv=%b rr=%b", c,
                     ifc.in_rsp_valid_o, ifc.out_rsp_ready_o, e_rsp_valid, e_rsp_ready); end
         for (int i = 0; i < N; i++) begin
            checks++; if (dut.cnt_q[i] !== 2'(m_cnt[i])) begin errors++;
               $display("FAIL rnd_cnt%0d cyc%0d got %0d want %0d", i, c, dut.cnt_q[i], m_cnt[i]); end
         end
         advance();
      end
      clear_inputs();
   endtask

   initial begin
      clear_inputs();
      model_reset();
      test_reset();
      test_rr_order();
      test_priority();
      test_lock();
      test_outstanding();
      test_rsp_route();
      test_reset_midop();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
